proc_control_fsm: RTL and testbench
===================================

# proc_control_fsm

Instruction-sequencing control unit for the 16-bit simple processor. Latches each instruction word from `DIN` into an internal instruction register and steps a four-state timing FSM. The FSM drives the one-hot bus-source selects (`ROut`, `GOut`, `DINOut`) consumed by the bus multiplexer, plus the register-load, ALU and completion strobes. It sits directly upstream of the bus multiplexer and is the only source of its select lines.

## Interface
Parameters: none; widths are fixed by the datapath.
- `Clock`  in  1  rising-edge clock
- `Resetn`  in  1  asynchronous, active-low reset
- `Run`  in  1  start request, sampled only in state T0
- `DIN`  in  16  instruction or immediate word; instruction fields: III=`DIN[15:13]`, XXX=`DIN[12:10]`, YYY=`DIN[9:7]`
- `Gzero`  in  1  high when register G == 0 (used only when `CTRL_MVNZ_EN` is defined)
- `IRin`  out  1  IR load strobe (mirrors internal IR load)
- `Rin`  out  8  one-hot load enable for R0..R7
- `ROut`  out  8  one-hot bus source select for R0..R7
- `GOut`  out  1  bus source = G
- `DINOut`  out  1  bus source = DIN
- `Ain`  out  1  load A from bus
- `Gin`  out  1  load G from ALU
- `AddSub`  out  1  0 = add, 1 = subtract
- `Done`  out  1  instruction completes this cycle

## Operation
- State register Tstep ∈ {T0, T1, T2, T3}, 2 bits. IR is 9 bits. Both are cleared asynchronously when `Resetn`=0.
- Outputs are combinational decode of (Tstep, IR, `Run`, `Gzero`); no output is registered.
- At most one of {`ROut` bits, `GOut`, `DINOut`} is high in any cycle; otherwise all are 0.
- X/Y decode: `Rin`/`ROut` = 8'b1 << XXX (or YYY).
- T0:
  - `Run`=1 → `IRin`=1, IR ← `DIN[15:7]`, next state T1.
  - `Run`=0 → hold T0, all outputs 0.
- mv (000): T1: `ROut`=Y, `Rin`=X, `Done`=1 → T0.
- mvi (001): T1: `DINOut`=1, `Rin`=X, `Done`=1 → T0. The immediate is the `DIN` word presented during T1.
- add (010) / sub (011):
  - T1: `ROut`=X, `Ain`=1 → T2.
  - T2: `ROut`=Y, `Gin`=1, `AddSub`=III[0] → T3.
  - T3: `GOut`=1, `Rin`=X, `Done`=1 → T0.
- Opcodes 100–111 (except as in Configuration): NOP. T1: `Done`=1 only → T0.
- X == Y is legal: mv Rk,Rk reloads itself; add Rk,Rk doubles Rk.
- `Run` is ignored in T1–T3. A `Run` held high back-to-back fetches a new instruction in the T0 immediately after `Done`.

## Timing
- Reset values: Tstep=T0, IR=0, and all outputs 0 (`Done`=0, `Rin`=0, `ROut`=0, `GOut`=0, `DINOut`=0, `Ain`=0, `Gin`=0, `AddSub`=0, `IRin`=0).
- Reset asserted mid-instruction: outputs drop to 0 asynchronously. No `Done` is issued for the aborted instruction. Operation restarts at T0 on the first clock edge after `Resetn` rises.
- Latency from the `Run`-sampling edge in T0 to `Done`:
  - mv / mvi / NOP: `Done` high during the 1st cycle after that edge.
  - add / sub: `Done` high during the 3rd cycle after that edge.
- Total cycles including T0: mv/mvi 2, add/sub 4.
- All register loads (`Rin`, `Ain`, `Gin`, IR) take effect on the rising edge that ends the cycle in which they are asserted.

## Configuration
- `CTRL_MVNZ_EN` defined: opcode 100 is mvnz.
  - T1, `Gzero`=0: `ROut`=Y, `Rin`=X, `Done`=1.
  - T1, `Gzero`=1: `Done`=1 only.
  - Next state T0 in both cases.
- `CTRL_MVNZ_EN` undefined: opcode 100 is a NOP and `Gzero` is unused.

## Test plan
- Reset: `Resetn`=0 while in T2 of an add → all outputs 0 immediately. After release with `Run`=1, the next fetch occurs in T0.
- mvi R3: T0 `DIN`=16'h2C00 with `Run`=1, then T1 `DIN`=16'h00A5 → in T1, `DINOut`=1, `Rin`=8'h08, `Done`=1.
- mv R1,R3: `DIN`=16'h0580 → in T1, `ROut`=8'h08, `Rin`=8'h02, `Done`=1; no other output high.
- sub R2,R5: `DIN`=16'h6A80 → sequence:
  - T1: `ROut`=8'h04, `Ain`=1.
  - T2: `ROut`=8'h20, `Gin`=1, `AddSub`=1.
  - T3: `GOut`=1, `Rin`=8'h04, `Done`=1.
- `Run`=0 for 5 cycles → FSM stays in T0 with all outputs 0. Back-to-back `Run`=1 over two mv instructions → `Done` on cycles 2 and 4.
- Opcode 100, `DIN`=16'h8580:
  - Macro undefined → T1 `Done`=1 only.
  - Macro defined, `Gzero`=0 → `ROut`=8'h08, `Rin`=8'h02.
  - Macro defined, `Gzero`=1 → `Rin`=0.

Source files
------------

// File: rtl/proc_control_fsm_if.sv
// proc_control_fsm_if: control-unit bundle between the sequencer and the datapath.
//   Inputs to the sequencer: Run (start request), DIN[15:0] (instruction/immediate),
//     Gzero (G == 0 flag).
//   Outputs from the sequencer: IRin, Rin[7:0], ROut[7:0], GOut, DINOut, Ain, Gin,
//     AddSub, Done.
//   master = sequencer side, slave = datapath side.
interface proc_control_fsm_if;
   logic        Run;
   logic [15:0] DIN;
   logic        Gzero;
   logic        IRin;
   logic [7:0]  Rin;
   logic [7:0]  ROut;
   logic        GOut;
   logic        DINOut;
   logic        Ain;
   logic        Gin;
   logic        AddSub;
   logic        Done;
   modport master (
      input  Run, DIN, Gzero,
      output IRin, Rin, ROut, GOut, DINOut, Ain, Gin, AddSub, Done
   );
   modport slave (
      output Run, DIN, Gzero,
      input  IRin, Rin, ROut, GOut, DINOut, Ain, Gin, AddSub, Done
   );
endinterface

// File: rtl/proc_control_fsm.sv
// proc_control_fsm: instruction register plus T0..T3 timing FSM for the 16-bit processor.
//   Clock  : rising-edge clock
//   Resetn : asynchronous active-low reset (clears Tstep and IR, forces outputs to 0)
//   ctrl   : proc_control_fsm_if.master (Run/DIN/Gzero in, bus selects and strobes out)
//   Optional feature: define CTRL_MVNZ_EN to turn opcode 100 into mvnz (move if G != 0).
module proc_control_fsm (
   input  logic                   Clock,
   input  logic                   Resetn,
   proc_control_fsm_if.master     ctrl
);
   typedef enum logic [1:0] {T0, T1, T2, T3} tstep_e;
   tstep_e     tstep_q, tstep_d;
   logic [8:0] ir_q, ir_d;
   logic [2:0] iii;
   logic [7:0] x_sel, y_sel;
   assign iii   = ir_q[8:6];
   assign x_sel = 8'd1 << ir_q[5:3];
   assign y_sel = 8'd1 << ir_q[2:0];
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         tstep_q <= T0;
         ir_q    <= '0;
      end else begin
         tstep_q <= tstep_d;
         ir_q    <= ir_d;
      end
   end
   always_comb begin
      tstep_d     = tstep_q;
      ir_d        = ir_q;
      ctrl.IRin   = 1'b0;
      ctrl.Rin    = '0;
      ctrl.ROut   = '0;
      ctrl.GOut   = 1'b0;
      ctrl.DINOut = 1'b0;
      ctrl.Ain    = 1'b0;
      ctrl.Gin    = 1'b0;
      ctrl.AddSub = 1'b0;
      ctrl.Done   = 1'b0;
      case (tstep_q)
         T0: begin
            // Resetn gating keeps IRin low while reset is held with Run high
            if (ctrl.Run && Resetn) begin
               ctrl.IRin = 1'b1;
               ir_d      = ctrl.DIN[15:7];
               tstep_d   = T1;
            end
         end
         T1: begin
            tstep_d = T0;
            case (iii)
               3'b000: begin
                  ctrl.ROut = y_sel;
                  ctrl.Rin  = x_sel;
                  ctrl.Done = 1'b1;
               end
               3'b001: begin
                  ctrl.DINOut = 1'b1;
                  ctrl.Rin    = x_sel;
                  ctrl.Done   = 1'b1;
               end
               3'b010, 3'b011: begin
                  ctrl.ROut = x_sel;
                  ctrl.Ain  = 1'b1;
                  tstep_d   = T2;
               end
`ifdef CTRL_MVNZ_EN
               3'b100: begin
                  if (!ctrl.Gzero) begin
                     ctrl.ROut = y_sel;
                     ctrl.Rin  = x_sel;
                  end
                  ctrl.Done = 1'b1;
               end
`endif
               default: ctrl.Done = 1'b1;
            endcase
         end
         T2: begin
            ctrl.ROut   = y_sel;
            ctrl.Gin    = 1'b1;
            ctrl.AddSub = iii[0];
            tstep_d     = T3;
         end
         T3: begin
            ctrl.GOut = 1'b1;
            ctrl.Rin  = x_sel;
            ctrl.Done = 1'b1;
            tstep_d   = T0;
         end
      endcase
   end
endmodule

// File: tb/tb_proc_control_fsm.sv
// tb_proc_control_fsm: directed plus randomized checks of proc_control_fsm against an
//   instruction-level reference model. Outputs are compared as the packed vector
//   {IRin, Rin, ROut, GOut, DINOut, Ain, Gin, AddSub, Done}.
module tb_proc_control_fsm;
   logic Clock = 1'b0;
   logic Resetn;
   int   passed = 0;
   int   total  = 0;
   proc_control_fsm_if bus();
   proc_control_fsm dut (.Clock(Clock), .Resetn(Resetn), .ctrl(bus));
   always #5 Clock = ~Clock;

   localparam logic [22:0] ZERO  = 23'h000000;
   localparam logic [22:0] FETCH = 23'h400000;

   function automatic logic [22:0] observed();
      return {bus.IRin, bus.Rin, bus.ROut, bus.GOut, bus.DINOut, bus.Ain, bus.Gin, bus.AddSub, bus.Done};
   endfunction

   // Expected outputs in the k-th cycle after the fetch edge, from instruction semantics.
   function automatic logic [22:0] mdl(input int k, input logic [15:0] ins, input logic gz);
      logic [2:0] op = ins[15:13];
      logic [7:0] rx = 8'd1 << ins[12:10];
      logic [7:0] ry = 8'd1 << ins[9:7];
      logic [7:0] rin = 8'h00, rout = 8'h00;
      logic gout = 0, dinout = 0, ain = 0, gin = 0, addsub = 0, done;
      logic arith = (op == 3'd2) || (op == 3'd3);
      logic mvnz = 1'b0;
`ifdef CTRL_MVNZ_EN
      mvnz = (op == 3'd4) && !gz;
`else
      mvnz = 1'b0 & gz;
`endif
      done = arith ? (k == 3) : (k == 1);
      if (op == 3'd0 || mvnz) begin rout = ry; rin = rx; end
      if (op == 3'd1) begin dinout = 1'b1; rin = rx; end
      if (arith) begin
         if (k == 1) begin rout = rx; ain = 1'b1; end
         if (k == 2) begin rout = ry; gin = 1'b1; addsub = op[0]; end
         if (k == 3) begin gout = 1'b1; rin = rx; end
      end
      return {1'b0, rin, rout, gout, dinout, ain, gin, addsub, done};
   endfunction

   task automatic chk(input string tag, input logic [22:0] exp);
      logic [22:0] obs = observed();
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic step(input string tag, input logic [22:0] exp);
      #2 chk(tag, exp);
      @(posedge Clock);
      #1;
   endtask

   task automatic exec(input logic [15:0] ins, input logic [15:0] imm, input logic gz);
      int n = (ins[15:13] == 3'd2 || ins[15:13] == 3'd3) ? 3 : 1;
      bus.Run = 1'b1; bus.DIN = ins; bus.Gzero = gz;
      step("fetch", FETCH);
      for (int k = 1; k <= n; k++) begin
         bus.Run   = 1'($urandom);
         bus.DIN   = (k == 1) ? imm : 16'($urandom);
         bus.Gzero = gz;
         step($sformatf("op%0d_t%0d_%h", ins[15:13], k, ins), mdl(k, ins, gz));
      end
      bus.Run = 1'b0;
   endtask

   initial begin
      Resetn = 1'b0; bus.Run = 1'b1; bus.DIN = 16'h2C00; bus.Gzero = 1'b0;
      @(posedge Clock); #1;
      step("reset_hold", ZERO);
      Resetn = 1'b1; bus.Run = 1'b0;
      for (int i = 0; i < 5; i++) step("idle", ZERO);
      exec(16'h2C00, 16'h00A5, 1'b0);
      bus.Run = 1'b1; bus.DIN = 16'h0580;
      step("mv_fetch", FETCH);
      bus.Run = 1'b0;
      step("mv_r1_r3", {1'b0, 8'h02, 8'h08, 6'b000001});
      bus.Run = 1'b1; bus.DIN = 16'h6A80;
      step("sub_fetch", FETCH);
      bus.Run = 1'b1;
      step("sub_t1", {1'b0, 8'h00, 8'h04, 6'b001000});
      step("sub_t2", {1'b0, 8'h00, 8'h20, 6'b000110});
      bus.Run = 1'b0;
      step("sub_t3", {1'b0, 8'h04, 8'h00, 6'b100001});
      exec(16'h0580, 16'h1234, 1'b0);
      exec(16'h0F00, 16'h5555, 1'b1);
      exec(16'h8580, 16'h0000, 1'b0);
      exec(16'h8580, 16'h0000, 1'b1);
      exec(16'h4A80, 16'h0000, 1'b0);
      exec(16'h4900, 16'h0000, 1'b0);
      // reset in T2 of an add, with Run held high
      bus.Run = 1'b1; bus.DIN = 16'h4A80;
      step("rst_fetch", FETCH);
      step("rst_t1", mdl(1, 16'h4A80, 1'b0));
      #2 chk("rst_t2", mdl(2, 16'h4A80, 1'b0));
      #1 Resetn = 1'b0;
      #1 chk("rst_async", ZERO);
      @(posedge Clock); #1;
      step("rst_held", ZERO);
      Resetn = 1'b1;
      exec(16'h0580, 16'h0000, 1'b0);
      for (int i = 0; i < 60; i++) begin
         logic [15:0] ins = 16'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            bus.Run = 1'b0; bus.DIN = 16'($urandom);
            step("rand_idle", ZERO);
         end
         exec(ins, 16'($urandom), 1'($urandom));
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
